// File: rtl/sha2_bridge_pkg.sv
// Shared types and constants for the SHA-2 host bridge.
package sha2_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    TXRESP = 3'd4,
    TXDIG  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_NEW  = 8'h01;
  localparam logic [7:0] CMD_CONT = 8'h02;
  localparam logic [7:0] CMD_READ = 8'h03;

endpackage

// File: rtl/sha2_bridge_digest_ser.sv
// Digest holding register plus a byte serialiser (MSB byte first) with a
// valid/ready output. The byte index restarts on 'start' and advances on
// every accepted byte, wrapping after the last one.
module sha2_bridge_digest_ser
  import sha2_bridge_pkg::*;
#(
  parameter int DIGEST_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [8*DIGEST_BYTES-1:0] load_data,
  input  logic                      start,
  input  logic                      en,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  output logic                      out_last
);

  localparam int IDX_W = $clog2(DIGEST_BYTES);

  logic [8*DIGEST_BYTES-1:0] dig_q, dig_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  // Next digest value and byte index
  always_comb begin
    dig_d = dig_q;
    idx_d = idx_q;
    if (load) dig_d = load_data;
    if (start) begin
      idx_d = '0;
    end else if (en && out_ready) begin
      idx_d = out_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Output byte mux: byte 0 lives in the top bits
  always_comb begin
    out_data = 8'h00;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      if (idx_q == IDX_W'(i)) out_data = dig_q[8*(DIGEST_BYTES-1-i) +: 8];
    end
  end

  assign out_valid = en;
  assign out_last  = (idx_q == IDX_W'(DIGEST_BYTES-1));

  // Digest and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      idx_q <= '0;
    end else begin
      dig_q <= dig_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/sha2_host_bridge.sv
// Host-side bridge between a UART byte stream and a SHA-2 compression core.
// Commands: 0x01 new message block, 0x02 continuation block, 0x03 read
// digest; anything else answers ERR_BYTE and sets the sticky error LED.
// Optional build macro SHA2_BRIDGE_TIMEOUT_EN adds an inter-byte timeout
// in LOAD that abandons the partial block and answers ERR_BYTE.
module sha2_host_bridge
  import sha2_bridge_pkg::*;
#(
  parameter int         BLOCK_BYTES    = 64,
  parameter int         DIGEST_BYTES   = 32,
  parameter logic [7:0] ACK_BYTE       = 8'hA5,
  parameter logic [7:0] ERR_BYTE       = 8'hEE,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [8*BLOCK_BYTES-1:0]  blk_data,
  output logic                      blk_first,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  input  logic [8*DIGEST_BYTES-1:0] dig_data,
  input  logic                      dig_valid,
  output logic [7:0]                led
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     first_q, first_d;
  logic [8*BLOCK_BYTES-1:0] blk_q, blk_d;
  logic [7:0]               resp_q, resp_d;
  logic                     err_q, err_d;
  logic                     dvld_q, dvld_d;
  logic [4:0]               blocks_q, blocks_d;

  logic       ser_load, ser_start, ser_en;
  logic [7:0] ser_data;
  logic       ser_valid, ser_last;

`ifdef SHA2_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    blk_d     = blk_q;
    resp_d    = resp_q;
    err_d     = err_q;
    dvld_d    = dvld_q;
    blocks_d  = blocks_q;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    blk_valid = 1'b0;
    ser_load  = 1'b0;
    ser_start = 1'b0;
    ser_en    = 1'b0;
`ifdef SHA2_BRIDGE_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          case (rx_data)
            CMD_NEW, CMD_CONT: begin
              state_d = LOAD;
              first_d = (rx_data == CMD_NEW);
              cnt_d   = '0;
`ifdef SHA2_BRIDGE_TIMEOUT_EN
              to_d    = '0;
`endif
            end
            CMD_READ: begin
              state_d   = TXDIG;
              ser_start = 1'b1;
            end
            default: begin
              state_d = TXRESP;
              resp_d  = ERR_BYTE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          for (int b = 0; b < BLOCK_BYTES; b++) begin
            if (cnt_q == CNT_W'(b)) blk_d[8*(BLOCK_BYTES-1-b) +: 8] = rx_data;
          end
          if (cnt_q == CNT_W'(BLOCK_BYTES-1)) begin
            state_d = SEND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`ifdef SHA2_BRIDGE_TIMEOUT_EN
          to_d = '0;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES-1)) begin
          // Host went quiet mid-block: drop what we have and report it
          state_d = TXRESP;
          cnt_d   = '0;
          resp_d  = ERR_BYTE;
          err_d   = 1'b1;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
`endif
        end
      end
      SEND: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = WAIT;
      end
      WAIT: begin
        // The core needs at least one cycle, so only look for the digest here
        if (dig_valid) begin
          ser_load = 1'b1;
          dvld_d   = 1'b1;
          blocks_d = blocks_q + 5'd1;
          resp_d   = ACK_BYTE;
          state_d  = TXRESP;
        end
      end
      TXRESP: begin
        tx_valid = 1'b1;
        tx_data  = resp_q;
        if (tx_ready) state_d = IDLE;
      end
      TXDIG: begin
        ser_en   = 1'b1;
        tx_valid = ser_valid;
        tx_data  = ser_data;
        if (tx_ready && ser_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign blk_data  = blk_q;
  assign blk_first = (state_q == SEND) && first_q;
  assign led       = {blocks_q, err_q, dvld_q, (state_q != IDLE)};

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      blk_q    <= '0;
      resp_q   <= 8'h00;
      err_q    <= 1'b0;
      dvld_q   <= 1'b0;
      blocks_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      blk_q    <= blk_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      dvld_q   <= dvld_d;
      blocks_q <= blocks_d;
    end
  end

`ifdef SHA2_BRIDGE_TIMEOUT_EN
  // Inter-byte idle counter for LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`endif

  sha2_bridge_digest_ser #(
    .DIGEST_BYTES(DIGEST_BYTES)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (dig_data),
    .start     (ser_start),
    .en        (ser_en),
    .out_ready (tx_ready),
    .out_data  (ser_data),
    .out_valid (ser_valid),
    .out_last  (ser_last)
  );

endmodule

// File: tb/tb_sha2_host_bridge.sv
// Directed, table-driven bench for sha2_host_bridge (64-byte block,
// 32-byte digest, timeout 100 cycles when the timeout build is enabled).
module tb_sha2_host_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [255:0] dig_data = '0;
  logic         dig_valid = 1'b0;
  logic [7:0]   led;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sha2_host_bridge #(
    .BLOCK_BYTES(64), .DIGEST_BYTES(32), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .dig_data(dig_data), .dig_valid(dig_valid),
    .led(led)
  );

  typedef struct { int idx; logic [7:0] exp; } slot_t;
  typedef struct { logic [7:0] cmd; logic [7:0] resp; } cmd_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] slot(input logic [511:0] blk, input int idx);
    logic [511:0] t;
    t = blk >> (8 * (63 - idx));
    return t[7:0];
  endfunction

  // Called and returns at a negedge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin @(negedge clk); n++; end
    if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_blk();
    int n = 0;
    while (!blk_valid && n < 100) begin @(negedge clk); n++; end
    chk("blk_valid_seen", 64'(blk_valid), 64'd1);
  endtask

  task automatic expect_tx(input string nm, input logic [7:0] exp, input int stall);
    int n = 0;
    while (!tx_valid && n < 300) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, 64'(tx_valid), 64'd1);
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_hold"}, 64'(tx_data), 64'(exp));
      @(negedge clk);
    end
    chk(nm, 64'(tx_data), 64'(exp));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic handshake_blk();
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic pulse_dig(input logic [255:0] d);
    dig_data = d;
    dig_valid = 1'b1;
    @(negedge clk);
    dig_valid = 1'b0;
  endtask

  initial begin
    slot_t        slots[7];
    cmd_t         cmds[4];
    logic [7:0]   dig_bytes[32];
    logic [255:0] dig_a;
    logic [255:0] dig_b;

    slots[0] = '{0, 8'h00};  slots[1] = '{1, 8'h01};  slots[2] = '{5, 8'h05};
    slots[3] = '{31, 8'h1F}; slots[4] = '{32, 8'h20}; slots[5] = '{62, 8'h3E};
    slots[6] = '{63, 8'h3F};
    cmds[0] = '{8'h7F, 8'hEE}; cmds[1] = '{8'h00, 8'hEE};
    cmds[2] = '{8'h04, 8'hEE}; cmds[3] = '{8'hFF, 8'hEE};
    dig_bytes[0] = 8'hDE; dig_bytes[1] = 8'hAD; dig_bytes[2] = 8'hBE; dig_bytes[3] = 8'hEF;
    for (int i = 4; i < 32; i++) dig_bytes[i] = 8'(8'h40 + i);
    dig_a = '0;
    for (int i = 0; i < 32; i++) dig_a = {dig_a[247:0], dig_bytes[i]};
    dig_b = {32{8'h22}};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 64'd1);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_blk_first", 64'(blk_first), 64'd0);
    chk("rst_blk_zero", 64'(|blk_data), 64'd0);
    chk("rst_led", 64'(led), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-LOAD after 10 bytes
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'hFF);
    chk("midload_busy", 64'(led[0]), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midload_led", 64'(led), 64'd0);
    chk("midload_rx_ready", 64'(rx_ready), 64'd1);
    chk("midload_tx_valid", 64'(tx_valid), 64'd0);
    chk("midload_blk_zero", 64'(|blk_data), 64'd0);

    // Fresh block 0x00..0x3F, delayed blk_ready
    send_byte(8'h01);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    wait_blk();
    chk("blk1_first", 64'(blk_first), 64'd1);
    for (int k = 0; k < 7; k++) chk("blk1_slot", 64'(slot(blk_data, slots[k].idx)), 64'(slots[k].exp));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("blk1_hold_valid", 64'(blk_valid), 64'd1);
      chk("blk1_hold_b0", 64'(slot(blk_data, 0)), 64'h00);
      chk("blk1_hold_b63", 64'(slot(blk_data, 63)), 64'h3F);
    end
    handshake_blk();
    chk("blk1_wait_novalid", 64'(blk_valid), 64'd0);
    chk("blk1_wait_busy", 64'(led[0]), 64'd1);
    @(negedge clk);
    pulse_dig(dig_a);
    expect_tx("blk1_ack", 8'hA5, 2);
    chk("blk1_led", 64'(led), 64'h0A);

    // Digest readback with tx_ready stalls
    send_byte(8'h03);
    for (int i = 0; i < 32; i++) expect_tx("dig_byte", dig_bytes[i], i % 2);
    chk("dig_idle", 64'(led[0]), 64'd0);
    chk("dig_no_tx", 64'(tx_valid), 64'd0);

    // Continuation block; stray dig_valid in SEND and on the accept edge
    send_byte(8'h02);
    for (int i = 0; i < 64; i++) send_byte(8'(8'hFF - i));
    wait_blk();
    chk("blk2_first", 64'(blk_first), 64'd0);
    chk("blk2_b0", 64'(slot(blk_data, 0)), 64'hFF);
    chk("blk2_b63", 64'(slot(blk_data, 63)), 64'hC0);
    pulse_dig({32{8'h11}});
    chk("blk2_send_ignore", 64'(blk_valid), 64'd1);
    chk("blk2_send_notx", 64'(tx_valid), 64'd0);
    dig_data = {32{8'h11}};
    dig_valid = 1'b1;
    handshake_blk();
    dig_valid = 1'b0;
    @(negedge clk);
    chk("blk2_same_edge_ignore", 64'(tx_valid), 64'd0);
    chk("blk2_blocks_before", 64'(led[7:3]), 64'd1);
    pulse_dig(dig_b);
    expect_tx("blk2_ack", 8'hA5, 0);
    chk("blk2_blocks", 64'(led[7:3]), 64'd2);
    send_byte(8'h03);
    for (int i = 0; i < 32; i++) expect_tx("dig2_byte", 8'h22, 0);

    // Bad commands
    for (int k = 0; k < 4; k++) begin
      send_byte(cmds[k].cmd);
      expect_tx("bad_cmd_resp", cmds[k].resp, 1);
      chk("bad_cmd_err", 64'(led[2]), 64'd1);
    end

    // Good hash after error keeps the sticky flag
    send_byte(8'h01);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    wait_blk();
    handshake_blk();
    pulse_dig(dig_a);
    expect_tx("blk3_ack", 8'hA5, 0);
    chk("blk3_led", 64'(led), 64'h1E);

`ifdef SHA2_BRIDGE_TIMEOUT_EN
    // Inter-byte timeout, then a normal hash
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h55);
    repeat (50) @(negedge clk);
    chk("to_not_early", 64'(tx_valid), 64'd0);
    expect_tx("to_err", 8'hEE, 0);
    chk("to_idle", 64'(led[0]), 64'd0);
    send_byte(8'h01);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    wait_blk();
    chk("to_blk_b0", 64'(slot(blk_data, 0)), 64'h00);
    chk("to_blk_b63", 64'(slot(blk_data, 63)), 64'h3F);
    handshake_blk();
    pulse_dig(dig_a);
    expect_tx("to_ack", 8'hA5, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sha2_host_bridge.md
Name: sha2_host_bridge

Overview:
- Parametrised host-side controller between a UART byte stream and a SHA-2 compression core.
- Accepts command bytes and payload bytes from the UART receiver and packs payload into message blocks. Hands each block to the core, latches the returned digest and streams the digest back to the UART transmitter.
- Sits between uart_rx/uart_tx and the hash core at the top level. Drives the board LEDs with status.
- Successor to the fixed single-mode controller: block/digest sizes are generic (SHA-224/256/384/512 capable) and a command protocol is added.

Parameters:
- BLOCK_BYTES, 64, message block size in bytes (64 for SHA-256 family, 128 for SHA-512).
- DIGEST_BYTES, 32, digest bytes returned by the core and sent on cmd 0x03.
- ACK_BYTE, 8'hA5, response byte after a block is hashed.
- ERR_BYTE, 8'hEE, response byte for a bad command or an abort.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock; everything synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data this cycle.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data.
- blk_data  out  8*BLOCK_BYTES  packed block; byte 0 in the MSBs (big-endian).
- blk_first  out  1  block starts a new message (core loads IV).
- blk_valid  out  1  block offered to the core.
- blk_ready  in  1  core accepts the block.
- dig_data  in  8*DIGEST_BYTES  digest from the core, MSB byte first.
- dig_valid  in  1  single-cycle pulse when dig_data is valid.
- led  out  8  status.

Behaviour:
- Handshakes: a transfer occurs when valid && ready on the same rising edge. Valid outputs, once asserted, hold their data stable until the transfer.
- Reset: state=IDLE; rx_ready=1; tx_valid=0; tx_data=0; blk_valid=0; blk_first=0; blk_data=0; byte count=0; digest register=0; led=0. Reset mid-operation abandons any block or transmission immediately, with no residual tx byte.
- States:
  - IDLE: rx_ready=1. On a received byte:
    - 0x01 → LOAD with first=1.
    - 0x02 → LOAD with first=0.
    - 0x03 → TXDIG with index=0.
    - any other byte → TXRESP(ERR_BYTE), and the sticky error flag is set.
  - LOAD: rx_ready=1. Each received byte is written to slot cnt (bits [8*(BLOCK_BYTES-cnt)-1 -: 8]) and cnt increments. When byte BLOCK_BYTES-1 is accepted, go to SEND on the next cycle with cnt=0. rx_ready=0 in every state other than IDLE and LOAD.
  - SEND: blk_valid=1 and blk_first=first. On blk_ready, go to WAIT.
  - WAIT: on dig_valid, latch dig_data into the digest register, set the digest-valid flag, increment the block counter, then go to TXRESP(ACK_BYTE).
  - TXRESP: tx_valid=1 with the response byte. On tx_ready, go to IDLE.
  - TXDIG: tx_data = digest byte idx (MSB first). Increment idx on each transfer. After byte DIGEST_BYTES-1 transfers, go to IDLE.
- Timing: the command byte does not occupy a block slot. A dig_valid outside WAIT is ignored. A dig_valid in the same cycle as the blk_ready transfer is also ignored; the core latency is at least 1 cycle.
- Cmd 0x03 before any hash sends the reset digest (all zeros).
- cnt width is $clog2(BLOCK_BYTES). idx width is $clog2(DIGEST_BYTES). Both are reset to 0 on every entry to their state.
- LEDs:
  - led[0] = state != IDLE.
  - led[1] = digest-valid flag.
  - led[2] = sticky error flag (cleared only by reset).
  - led[7:3] = blocks hashed mod 32; the counter wraps 31→0.

Optional Feature:
- Macro SHA2_BRIDGE_TIMEOUT_EN.
- Defined: a counter in LOAD resets on each accepted byte. When it reaches TIMEOUT_CYCLES with no byte received:
  - the partial block is discarded and cnt=0;
  - the sticky error flag is set;
  - the state goes to TXRESP(ERR_BYTE).
- Not defined: LOAD waits indefinitely, the counter logic is absent and TIMEOUT_CYCLES is unused.

Decomposition:
- Package sha2_bridge_pkg:
  - state enum (IDLE, LOAD, SEND, WAIT, TXRESP, TXDIG);
  - command constants CMD_NEW=8'h01, CMD_CONT=8'h02, CMD_READ=8'h03.
- One natural sub-module: sha2_bridge_digest_ser, which latches the digest and serialises it byte-wise with a valid/ready output.

Test Plan:
- Reset held low mid-LOAD (after 10 of 64 bytes), then released → IDLE; led=0; the next 0x01 plus 64 bytes produce a fresh block with no stale data.
- 0x01 then bytes 0x00..0x3F → blk_data[511:504]=0x00, blk_data[7:0]=0x3F, blk_first=1. With blk_ready delayed 5 cycles, blk_valid and blk_data stay stable. A dig_valid pulse produces tx 0xA5; led[1]=1 and led[7:3]=1.
- 0x03 after that hash, with dig_data=32'hDEADBEEF in the MSBs and tx_ready toggling → tx sequence DE AD BE EF ... (32 bytes) in order. Each byte is held until tx_ready; the block returns to IDLE after byte 31.
- 0x02 plus 64 bytes → blk_first=0. A dig_valid during SEND is ignored; only the later pulse in WAIT is latched.
- Command 0x7F → tx 0xEE; led[2]=1 and stays set after a subsequent good hash.
- With SHA2_BRIDGE_TIMEOUT_EN defined and TIMEOUT_CYCLES=100: 0x01 plus 3 bytes, then idle for 100 cycles → tx 0xEE and return to IDLE; a new 0x01 plus 64 bytes hashes normally.
